reg_spill_ctrl: RTL

- Initiator-side engine that drives the register file's write/read ports and the data memory port to move a block of registers.
- Spill copies consecutive registers into data memory; fill copies consecutive memory bytes into registers.
- Sits beside the register file in the datapath. The control unit issues one command and then waits for done.
- Transfers one byte per cycle, using the register file's combinational read and clocked write.

---
 rtl/reg_spill_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_spill_ctrl.sv
// Register spill/fill engine: moves a block of bytes between the register file
// and data memory, one byte per cycle, then pulses done.
module reg_spill_ctrl #(
   parameter int unsigned NREGS = 8,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          dir,
   input  logic [3:0]    base_reg,
   input  logic [3:0]    count,
   input  logic [AW-1:0] mem_base,
   output logic [3:0]    rf_addr,
   output logic          rf_wr_en,
   output logic [7:0]    rf_dat_out,
   input  logic [7:0]    rf_dat_in,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [7:0]    mem_dat_out,
   input  logic [7:0]    mem_dat_in,
   output logic          busy,
   output logic          done
);

   localparam int unsigned RIW = 4;
   localparam int unsigned CW  = 4;
   localparam logic [RIW-1:0] REG_MASK = RIW'(NREGS - 1);
   localparam logic [RIW-1:0] REG_ONE  = RIW'(1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [AW-1:0]  MEM_ONE  = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e          state_q,     state_d;
   logic            dir_q,       dir_d;
   logic [RIW-1:0]  cur_reg_q,   cur_reg_d;
   logic [AW-1:0]   cur_mem_q,   cur_mem_d;
   logic [CW-1:0]   remaining_q, remaining_d;

   // State and captured command fields; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         dir_q       <= 1'b0;
         cur_reg_q   <= '0;
         cur_mem_q   <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         cur_reg_q   <= cur_reg_d;
         cur_mem_q   <= cur_mem_d;
         remaining_q <= remaining_d;
      end
   end

   // Next state and port drive; everything is quiet (zero) outside XFER.
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      cur_reg_d   = cur_reg_q;
      cur_mem_d   = cur_mem_q;
      remaining_d = remaining_q;
      busy        = 1'b0;
      done        = 1'b0;
      rf_addr     = '0;
      rf_wr_en    = 1'b0;
      rf_dat_out  = '0;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_dat_out = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dir_d       = dir;
               cur_reg_d   = base_reg & REG_MASK;
               cur_mem_d   = mem_base;
               remaining_d = count;
               state_d     = (count == '0) ? S_DONE : S_XFER;
            end
         end
         S_XFER: begin
            busy     = 1'b1;
            rf_addr  = cur_reg_q;
            mem_addr = cur_mem_q;
            // Data passes straight through: the read ports are combinational.
            if (dir_q) begin
               rf_dat_out = mem_dat_in;
               rf_wr_en   = 1'b1;
            end else begin
               mem_dat_out = rf_dat_in;
               mem_wr_en   = 1'b1;
            end
            cur_reg_d   = (cur_reg_q + REG_ONE) & REG_MASK;
            cur_mem_d   = cur_mem_q + MEM_ONE;
            remaining_d = remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
